axis_effect_slot: RTL and testbench
===================================

# axis_effect_slot

Parametrised, click-free bypass wrapper for one effect stage in the stereo AXI-Stream audio chain. It sits between two stages of the chain and fans each input word out to an attached effect core and to a latency-matching dry FIFO. It recombines the effect output ("wet") with the buffered input ("dry") using a per-frame wet/dry gain ramp. It replaces hard enable-switch bypassing, so every stage gains smooth fade-in/fade-out and a framing-error check.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every AXIS data bus.
- SAMPLE_WIDTH, 24, signed sample held in data[SAMPLE_WIDTH-1:0]; upper bits are sign extension.
- GAIN_BITS, 8, gain resolution; FULL = 2^GAIN_BITS; a full ramp takes FULL frames.
- FIFO_DEPTH, 16, dry FIFO depth in words; power of two, ≥ 2.

Ports:
- clk  in  1  audio clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  target state: 1 = fully wet, 0 = fully dry; quasi-static switch input.
- s_axis_data/valid/ready/last  in/in/out/in  DATA_WIDTH/1/1/1  chain input; last marks the final channel of a frame.
- fx_tx_data/valid/ready/last  out/out/in/out  DATA_WIDTH/1/1/1  to effect core input.
- fx_rx_data/valid/ready/last  in/in/out/in  DATA_WIDTH/1/1/1  from effect core output; in order, one word per fx_tx word.
- m_axis_data/valid/ready/last  out/out/in/out  DATA_WIDTH/1/1/1  chain output.
- state  out  2  0 BYPASS, 1 FADE_IN, 2 ACTIVE, 3 FADE_OUT.
- gain  out  GAIN_BITS+1  current wet gain, 0..FULL.
- framing_err  out  1  sticky flag.

## Operation
- Input fan-out: fx_tx_valid = s_axis_valid & ~fifo_full; s_axis_ready = fx_tx_ready & ~fifo_full. fx_tx_data/last equal s_axis_data/last combinationally.
- On every s_axis transfer the word and its last bit are pushed into the dry FIFO.
- Dry words are never dropped. A full FIFO stalls the input.
- Recombine: fx_rx_ready = ~fifo_empty & (~m_axis_valid | m_axis_ready).
- On every fx_rx transfer, one dry word is popped. The mix is registered into the output register, and m_axis_valid is set.
- Mix arithmetic:
  - Sign-extend wet and dry from SAMPLE_WIDTH.
  - Compute sum = wet*g + dry*(FULL-g) at full precision, SAMPLE_WIDTH+GAIN_BITS+1 bits signed.
  - Result = sum >>> GAIN_BITS (floor). Sign-extend the result to DATA_WIDTH.
  - g=0 yields exactly dry; g=FULL yields exactly wet. No saturation is needed because the mix is a convex combination.
- m_axis_last = popped dry last.
- If fx_rx_last ≠ dry last on a transfer, framing_err sets and holds until reset. Data flow continues.
- Gain FSM (g updates only when a word with last=1 is registered into the output; both channels of a frame share one g):
  - BYPASS (g=0): enable=1 → FADE_IN.
  - FADE_IN: g += 1 per frame. Reaching FULL → ACTIVE. enable=0 → FADE_OUT from the current g, with no jump.
  - ACTIVE (g=FULL): enable=0 → FADE_OUT.
  - FADE_OUT: g -= 1 per frame. Reaching 0 → BYPASS. enable=1 → FADE_IN from the current g.
  - The FSM state transition is evaluated every cycle. Only g steps at frame ends.
- The effect core is clocked and fed in every state. In BYPASS its output is consumed and discarded by the g=0 weighting.
- An fx_rx word arriving while the FIFO is empty is not accepted (fx_rx_ready low). This can only occur with a non-conforming core.

## Timing
- Reset (asynchronous assert, synchronous release) drives: m_axis_valid=0, m_axis_data=0, m_axis_last=0, state=BYPASS, gain=0, framing_err=0, FIFO empty.
- Consequently s_axis_ready=fx_tx_ready and fx_rx_ready=0 during and after reset.
- Reset mid-fade or mid-frame discards all buffered words. Output resumes from BYPASS; with enable=1 it fades in again.
- Latency: s_axis transfer → m_axis_valid equals the effect-core latency + 1 cycle (output register).
- Throughput: one word per cycle when the core and downstream are ready.
- Words in flight inside the core are limited to FIFO_DEPTH. Cores with deeper pipelines require a larger FIFO_DEPTH.
- m_axis_valid, once high, holds with stable data/last until m_axis_ready. fx_tx_valid does not depend on fx_tx_ready.
- A simultaneous FIFO push and pop when full: the push is blocked (full is evaluated before the pop). When empty, the pop is blocked.
- The enable toggle takes effect on the next clock. The first gain step occurs at the next frame end.

## Test plan
- enable=0, dry=0x000100, core returns wet=0x000300, latency 3 → every output word = 0x000100; state=0, gain=0.
- Raise enable with the same stimulus → gain steps 1/frame. Frame 128 output = 0x000200; after 256 frames output = 0x000300; state=2.
- g=128, dry=0xFFFF00 (−256), wet=0x000100 → output 0x00000000. Repeat with g=FULL → output 0x00000100.
- Core latency 3, FIFO_DEPTH=16, m_axis_ready low for 40 cycles → s_axis_ready drops once the FIFO holds 16 words. After release, a 200-word ramp sequence emerges complete, in order, and unduplicated.
- Drop enable at gain=100 during FADE_IN → state=3 and gain 100, 99, 98… with no step greater than 1. Core injects wet last=1 on a left word → framing_err=1 and it stays set.
- Assert resetn low mid-FADE_OUT with 5 words buffered → all outputs read 0 immediately. After release the first output equals the dry of the first new input.

Source files
------------

// File: rtl/axis_effect_slot.sv
// Crossfading bypass around one AXIS effect core. The dry path is a FIFO that absorbs the core's latency.
// Latency is core latency + 1. A full dry FIFO stalls the input; a stalled output stops the core drain.
module axis_effect_slot #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int GAIN_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] fx_tx_data,
  output logic                  fx_tx_valid,
  input  logic                  fx_tx_ready,
  output logic                  fx_tx_last,
  input  logic [DATA_WIDTH-1:0] fx_rx_data,
  input  logic                  fx_rx_valid,
  output logic                  fx_rx_ready,
  input  logic                  fx_rx_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [1:0]            state,
  output logic [GAIN_BITS:0]    gain,
  output logic                  framing_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = SAMPLE_WIDTH + GAIN_BITS + 2;
  localparam int XS = DATA_WIDTH - SAMPLE_WIDTH;
  localparam logic [GAIN_BITS:0] FULL = {1'b1, {GAIN_BITS{1'b0}}};

  typedef enum logic [1:0] {
    BYPASS   = 2'd0,
    FADE_IN  = 2'd1,
    ACTIVE   = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  logic [DATA_WIDTH:0]          r_mem [FIFO_DEPTH];
  logic [AW:0]                  r_wr_ptr, r_rd_ptr;
  logic                         w_full, w_empty, w_push, w_pop;
  logic                         w_frame_end, w_step_up, w_step_dn;
  logic [DATA_WIDTH:0]          w_dry_ent;
  logic signed [DATA_WIDTH-1:0] w_wet_x, w_dry_x;
  logic signed [PW-1:0]         w_wet_s, w_dry_s, w_g_s, w_ng_s, w_sum;
  logic [DATA_WIDTH-1:0]        w_mix_dat;
  logic [DATA_WIDTH-1:0]        r_m_data;
  logic                         r_m_valid, r_m_last, r_ferr;
  state_t                       r_state, w_state_nxt;
  logic [GAIN_BITS:0]           r_gain;

  assign w_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign fx_tx_valid  = s_axis_valid & ~w_full;
  assign s_axis_ready = fx_tx_ready & ~w_full;
  assign fx_tx_data   = s_axis_data;
  assign fx_tx_last   = s_axis_last;
  assign fx_rx_ready  = ~w_empty & (~r_m_valid | m_axis_ready);

  assign w_push    = s_axis_valid & s_axis_ready;
  assign w_pop     = fx_rx_valid & fx_rx_ready;
  assign w_dry_ent = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_last, s_axis_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Shift up then arithmetic-shift down: sign-extends from SAMPLE_WIDTH regardless of the upper bits.
  assign w_wet_x   = $signed(fx_rx_data << XS) >>> XS;
  assign w_dry_x   = $signed(w_dry_ent[DATA_WIDTH-1:0] << XS) >>> XS;
  assign w_wet_s   = PW'(w_wet_x);
  assign w_dry_s   = PW'(w_dry_x);
  assign w_g_s     = PW'(r_gain);
  assign w_ng_s    = PW'(FULL - r_gain);
  assign w_sum     = w_wet_s * w_g_s + w_dry_s * w_ng_s;
  assign w_mix_dat = DATA_WIDTH'(w_sum >>> GAIN_BITS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_mix_dat;
        r_m_last  <= w_dry_ent[DATA_WIDTH];
        if (fx_rx_last != w_dry_ent[DATA_WIDTH]) r_ferr <= 1'b1;
      end else if (m_axis_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign w_frame_end = w_pop & w_dry_ent[DATA_WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= BYPASS;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BYPASS:   if (enable) w_state_nxt = FADE_IN;
      FADE_IN:  if (!enable) w_state_nxt = FADE_OUT;
                else if (r_gain == FULL) w_state_nxt = ACTIVE;
      ACTIVE:   if (!enable) w_state_nxt = FADE_OUT;
      FADE_OUT: if (enable) w_state_nxt = FADE_IN;
                else if (r_gain == '0) w_state_nxt = BYPASS;
      default:  w_state_nxt = BYPASS;
    endcase
  end

  // Gain moves only on the last channel of a frame, so both channels share one weight.
  always_comb begin
    w_step_up = 1'b0;
    w_step_dn = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        FADE_IN:  w_step_up = (r_gain != FULL);
        FADE_OUT: w_step_dn = (r_gain != '0);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        r_gain <= '0;
    else if (w_step_up) r_gain <= r_gain + (GAIN_BITS+1)'(1);
    else if (w_step_dn) r_gain <= r_gain - (GAIN_BITS+1)'(1);
  end

  assign m_axis_data  = r_m_data;
  assign m_axis_valid = r_m_valid;
  assign m_axis_last  = r_m_last;
  assign state        = r_state;
  assign gain         = r_gain;
  assign framing_err  = r_ferr;

endmodule

// File: tb/tb_axis_effect_slot.sv
// Scoreboarded bench for axis_effect_slot with a fixed-latency effect core model and a per-frame gain model.
module tb_axis_effect_slot;
  localparam int DW = 32, DEPTH = 16, FULL = 256, LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, enable;
  logic [DW-1:0] s_axis_data, fx_tx_data, fx_rx_data, m_axis_data;
  logic          s_axis_valid, s_axis_ready, s_axis_last;
  logic          fx_tx_valid, fx_tx_ready, fx_tx_last;
  logic          fx_rx_valid, fx_rx_ready, fx_rx_last;
  logic          m_axis_valid, m_axis_ready, m_axis_last;
  logic [1:0]    state;
  logic [8:0]    gain;
  logic          framing_err;

  axis_effect_slot #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24), .GAIN_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .fx_tx_data(fx_tx_data), .fx_tx_valid(fx_tx_valid), .fx_tx_ready(fx_tx_ready), .fx_tx_last(fx_tx_last),
    .fx_rx_data(fx_rx_data), .fx_rx_valid(fx_rx_valid), .fx_rx_ready(fx_rx_ready), .fx_rx_last(fx_rx_last),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
    .state(state), .gain(gain), .framing_err(framing_err)
  );

  typedef struct { logic [31:0] d; logic l; } exp_t;
  typedef struct { logic [31:0] d; logic l; int t; } core_t;
  exp_t  sb_q[$];
  core_t core_q[$];

  int n_pass = 0, n_chk = 0, cyc = 0, mg = 0, n_acc = 0, inj_req = 0;
  bit men = 0, mferr = 0, core_const = 1, rand_bp = 0, gaps = 0, ds_hold = 0, got_first = 0;
  logic [31:0] core_wet = 32'h300, first_out = 32'h0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic longint sx(input logic [31:0] d);
    logic signed [23:0] s;
    s = d[23:0];
    return longint'(s);
  endfunction

  function automatic longint fdiv(input longint s);
    longint q;
    q = s / FULL;
    if (s < 0 && q * FULL != s) q = q - 1;
    return q;
  endfunction

  function automatic int exp_state();
    if (men) return (mg == FULL) ? 2 : 1;
    return (mg == 0) ? 0 : 3;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Effect core: fixed latency, in-order, constant or negating wet output.
  initial begin
    bit tx_f, rx_f, rst_s, tx_l;
    logic [31:0] tx_d;
    longint ws;
    core_t c;
    int inj_done;
    inj_done = 0;
    fx_rx_valid = 0; fx_rx_data = 0; fx_rx_last = 0; fx_tx_ready = 1;
    forever begin
      @(negedge clk);
      tx_f = fx_tx_valid && fx_tx_ready;
      rx_f = fx_rx_valid && fx_rx_ready;
      rst_s = !resetn;
      tx_d = fx_tx_data;
      tx_l = fx_tx_last;
      @(posedge clk); #1;
      if (rst_s) core_q.delete();
      else begin
        if (rx_f) void'(core_q.pop_front());
        if (tx_f) begin
          ws = core_const ? sx(core_wet) : -sx(tx_d);
          c.d = ws[31:0];
          c.l = tx_l;
          if (inj_req != inj_done) begin
            c.l = ~tx_l;
            inj_done++;
          end
          c.t = cyc + LAT;
          core_q.push_back(c);
        end
      end
      if (core_q.size() > 0 && core_q[0].t <= cyc) begin
        fx_rx_valid = 1; fx_rx_data = core_q[0].d; fx_rx_last = core_q[0].l;
      end else begin
        fx_rx_valid = 0;
      end
      fx_tx_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    m_axis_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (ds_hold)      m_axis_ready = 0;
      else if (rand_bp) m_axis_ready = ($urandom_range(0, 2) != 0);
      else              m_axis_ready = 1;
    end
  end

  // Monitor: compares every output transfer against the scoreboard and checks hold-while-stalled.
  initial begin
    bit stall;
    logic [31:0] hd;
    logic hl;
    exp_t e;
    stall = 0; hd = 0; hl = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall = 0;
        got_first = 0;
      end else begin
        if (stall) chk("hold_stable", m_axis_valid && m_axis_data == hd && m_axis_last == hl, 1);
        if (m_axis_valid && m_axis_ready) begin
          if (!got_first) begin
            got_first = 1;
            first_out = m_axis_data;
          end
          if (sb_q.size() == 0) chk("unexpected_out", m_axis_data, 32'hdeadbeef);
          else begin
            e = sb_q.pop_front();
            chk("out_data", m_axis_data, e.d);
            chk("out_last", m_axis_last, e.l);
          end
          stall = 0;
        end else if (m_axis_valid) begin
          stall = 1; hd = m_axis_data; hl = m_axis_last;
        end else stall = 0;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    longint wet, dry, q;
    exp_t e;
    int w;
    bit fired;
    if (gaps) begin
      s_axis_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_axis_data = d; s_axis_last = l; s_axis_valid = 1;
    w = 0; fired = 0;
    while (!fired && w < 3000) begin
      @(negedge clk);
      fired = s_axis_ready;
      w++;
    end
    @(posedge clk); #1;
    s_axis_valid = 0;
    chk("send_accept", fired, 1);
    if (fired) begin
      wet = core_const ? sx(core_wet) : -sx(d);
      dry = sx(d);
      q = fdiv(wet * mg + dry * (FULL - mg));
      e.d = q[31:0]; e.l = l;
      sb_q.push_back(e);
      n_acc++;
      if (l) mg = men ? ((mg < FULL) ? mg + 1 : FULL) : ((mg > 0) ? mg - 1 : 0);
    end
  endtask

  task automatic send_frames(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      send_word(d, 1'b0);
      send_word(d, 1'b1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 5000) begin @(posedge clk); w++; end
    chk("drained", sb_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit v);
    enable = v; men = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_state();
    chk("state", state, exp_state());
    chk("gain", gain, mg);
    chk("framing_err", framing_err, mferr);
  endtask

  initial begin
    int prev;
    resetn = 0; enable = 0; s_axis_valid = 0; s_axis_data = 0; s_axis_last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_axis_valid, 0);
    chk("rst_m_data", m_axis_data, 0);
    chk("rst_m_last", m_axis_last, 0);
    chk("rst_fx_rx_ready", fx_rx_ready, 0);
    chk("rst_s_ready", s_axis_ready, 1);
    chk_state();
    resetn = 1;
    repeat (2) @(posedge clk);
    #1;

    send_frames(8, 32'h100);
    drain();
    chk_state();

    set_en(1);
    send_frames(128, 32'h100);
    drain();
    chk_state();
    send_frames(128, 32'h100);
    drain();
    chk_state();

    set_en(0);
    send_frames(128, 32'h100);
    drain();
    core_wet = 32'h100;
    send_frames(1, 32'h00FFFF00);
    drain();
    set_en(1);
    send_frames(129, 32'h100);
    drain();
    chk_state();
    send_frames(1, 32'h00FFFF00);
    drain();
    chk_state();

    core_const = 0; rand_bp = 1; gaps = 1;
    set_en(0);
    for (int i = 0; i < 120; i++) send_word(32'($urandom_range(0, 8388607)) - 32'h400000, i[0]);
    drain();
    rand_bp = 0; gaps = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_state();

    ds_hold = 1;
    repeat (2) @(posedge clk);
    #1;
    n_acc = 0;
    fork
      for (int i = 0; i < 200; i++) send_word(32'(i * 1000 - 100000), i[0]);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", n_acc, DEPTH + 1);
        chk("bp_s_ready", s_axis_ready, 0);
        ds_hold = 0;
      end
    join
    drain();
    chk_state();

    set_en(1);
    while (mg < 100) send_frames(1, 32'h100);
    drain();
    chk_state();
    set_en(0);
    chk_state();
    for (int k = 0; k < 5; k++) begin
      prev = gain;
      send_frames(1, 32'h100);
      drain();
      chk("fade_step", prev - gain, 1);
      chk_state();
    end
    inj_req++;
    mferr = 1;
    send_frames(1, 32'h100);
    drain();
    chk_state();
    send_frames(1, 32'h100);
    drain();
    chk_state();

    ds_hold = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_word(32'h100 + i, i[0]);
    repeat (6) @(posedge clk);
    #2;
    resetn = 0;
    #1;
    chk("mid_rst_m_valid", m_axis_valid, 0);
    chk("mid_rst_m_data", m_axis_data, 0);
    chk("mid_rst_m_last", m_axis_last, 0);
    chk("mid_rst_fx_rx_ready", fx_rx_ready, 0);
    sb_q.delete();
    mg = 0; mferr = 0; ds_hold = 0;
    chk_state();
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1;
    repeat (2) @(posedge clk);
    #1;
    send_word(32'h00012345, 1'b0);
    send_word(32'h00FEDCBA, 1'b1);
    drain();
    chk("post_rst_first", first_out, 32'h00012345);
    chk_state();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
